e1000_tx_intr_moderator: RTL and testbench
==========================================

Name: e1000_tx_intr_moderator

Overview:
- Generates the E1000 transmit interrupt cause events TXDW, TXQE and TXD_LOW for the NIC transmit path.
- Sits directly downstream of the TX descriptor write-back engine. It consumes each write-back event together with live ring pointers (TDH/TDT/TDLEN) and the TIDV/TADV/TXDCTL register values.
- Emits one-cycle cause pulses to the ICR/IMS interrupt register block, which drives INTA_N.
- Implements the TIDV (inter-packet delay) and TADV (absolute delay) timers in 1.024 us units.

Parameters:
TICK_CYCLES, 128, aclk cycles per 1.024 us timer tick (128 at 125 MHz).
IDX_WIDTH, 16, width of descriptor index and ring length in descriptors.

Ports:
aclk  in  1  clock
rst  in  1  synchronous active-high reset
tx_en  in  1  TCTL.EN; low = block idle, timers cleared
wb_valid  in  1  one-cycle pulse: one descriptor written back (DD set)
wb_ide  in  1  IDE bit of the written-back descriptor
wb_rs  in  1  RS bit of the written-back descriptor
tdh  in  IDX_WIDTH  ring head (descriptor index)
tdt  in  IDX_WIDTH  ring tail (descriptor index)
ring_len  in  IDX_WIDTH  ring length in descriptors (TDLEN/16); 0 = ring invalid
tidv  in  16  TIDV.IDV in ticks
tadv  in  16  TADV.IDV in ticks
lwthresh  in  7  TXDCTL.LWTHRESH; threshold = lwthresh*8 descriptors; 0 disables
flush  in  1  one-cycle pulse: TIDV write with FPD (bit 31) set
txdw_set  out  1  one-cycle TXDW cause pulse
txqe_set  out  1  one-cycle TXQE cause pulse
txd_low_set  out  1  one-cycle TXD_LOW cause pulse
delay_pending  out  1  a TXDW event is being held by TIDV/TADV

Behaviour:
- Reset: all outputs 0; prescaler, tidv_cnt and tadv_cnt at 0; both timers stopped; prev_empty = 1; prev_pending = 0.
- Prescaler: counts 0..TICK_CYCLES-1 while tx_en=1; `tick` is asserted for one cycle when the count wraps. It is held at 0 when tx_en=0.
- Write-back qualification: only wb_valid with wb_rs=1 counts; write-backs with RS=0 are ignored.
- Immediate TXDW path: a qualified write-back with wb_ide=0, or with tidv=0, drives txdw_set=1 on the next cycle (1-cycle latency). This also cancels any held delay: both timers stop and delay_pending drops.
- Delayed path (wb_ide=1, tidv!=0):
  - tidv_cnt reloads to tidv on every such write-back.
  - tadv_cnt loads tadv only if TADV is not already running and tadv!=0.
  - delay_pending=1 from the next cycle.
- Countdown: on each tick, each running counter decrements by 1. When either running counter reaches 0, txdw_set pulses on the following cycle, both timers stop, and delay_pending drops.
- Reload priority: if a reload and an expiry occur in the same cycle, the reload wins for TIDV and no pulse is emitted. TADV expiry in that same cycle still fires.
- Flush: a flush pulse while delay_pending=1 fires txdw_set next cycle and stops both timers. With delay_pending=0 it has no effect.
- Pending count: pending = tdt-tdh if tdt>=tdh, else tdt+ring_len-tdh, computed in IDX_WIDTH+1 bits and registered each cycle. ring_len=0 forces pending=0 and suppresses TXQE/TXD_LOW.
- TXQE: empty = (tdh==tdt). txqe_set pulses for one cycle on a registered transition of empty from 0 to 1 while tx_en=1. It does not pulse on a tx_en rising edge with an already-empty ring.
- TXD_LOW: thr = lwthresh*8 (10 bits). txd_low_set pulses for one cycle when prev_pending >= thr and pending < thr, with lwthresh!=0 and tx_en=1. Each crossing produces one pulse; re-arming requires pending >= thr again.
- Simultaneous events: txdw_set, txqe_set and txd_low_set are independent and may assert in the same cycle.
- tx_en deassertion:
  - Next cycle: timers cleared, delay_pending=0, no cause pulses.
  - A held TXDW is discarded, not fired.
  - prev_empty is set to 1.
- rst mid-countdown: all state returns to reset values; no pulse is emitted.

Test Plan:
- tx_en=1, ring_len=8, one write-back with wb_rs=1, wb_ide=0 -> txdw_set exactly 1 cycle, 1 cycle after wb_valid; delay_pending stays 0.
- TICK_CYCLES=4, tidv=16, tadv=0, wb_ide=1 write-backs at cycle 0 and cycle 40 -> single txdw_set at cycle 40+64+1 (±prescaler phase ≤4); none at ~65.
- TICK_CYCLES=4, tidv=16, tadv=32, wb_ide=1 write-back every 30 cycles -> TIDV never expires; txdw_set at ~129 cycles after the first write-back (TADV); delay_pending drops there.
- ring_len=16, tdt=10, tdh advancing 3→10 -> txqe_set once at the tdh=10 cycle+1. Also tdh wraps 15→0 with tdt=2 -> pending computed as 2 and no spurious TXQE.
- lwthresh=1 (thr=8), tdt=12, tdh stepping 0→12 -> txd_low_set exactly once when pending goes 8→7 (tdh=5); no further pulse until pending ≥8 again.
- Held TIDV event with flush pulse -> txdw_set next cycle. Repeat with tx_en dropped (or rst pulsed) during the countdown -> no txdw_set, delay_pending=0 next cycle.

Source files
------------

// File: rtl/e1000_tx_intr_moderator.sv
`default_nettype none
// ============================================================================
//  Module   : e1000_tx_intr_moderator
//  Purpose  : Generates the E1000 transmit interrupt causes TXDW, TXQE and
//             TXD_LOW from descriptor write-back events and the live TX ring
//             pointers. TXDW can be held back by the TIDV (inter-packet) and
//             TADV (absolute) delay timers, which count in 1.024 us ticks.
//  Ports    :
//    aclk, rst           clock, synchronous active-high reset
//    tx_en               TCTL.EN; low parks the block and clears the timers
//    wb_valid/ide/rs     one descriptor written back, with its IDE/RS bits
//    tdh, tdt, ring_len  ring head, tail and length in descriptors
//    tidv, tadv          delay timer reload values in ticks
//    lwthresh            TXDCTL.LWTHRESH (threshold = lwthresh*8, 0 = off)
//    flush               TIDV write with FPD set
//    txdw_set, txqe_set, txd_low_set   one-cycle cause pulses to ICR
//    delay_pending       a TXDW event is currently being held
//  Revision : 1.0  initial release
// ============================================================================
module e1000_tx_intr_moderator #(
   parameter int TICK_CYCLES = 128,
   parameter int IDX_WIDTH   = 16
) (
   input  logic                 aclk,
   input  logic                 rst,
   input  logic                 tx_en,
   input  logic                 wb_valid,
   input  logic                 wb_ide,
   input  logic                 wb_rs,
   input  logic [IDX_WIDTH-1:0] tdh,
   input  logic [IDX_WIDTH-1:0] tdt,
   input  logic [IDX_WIDTH-1:0] ring_len,
   input  logic [15:0]          tidv,
   input  logic [15:0]          tadv,
   input  logic [6:0]           lwthresh,
   input  logic                 flush,
   output logic                 txdw_set,
   output logic                 txqe_set,
   output logic                 txd_low_set,
   output logic                 delay_pending
);

   localparam int PS_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int PEND_W = IDX_WIDTH + 1;
   // Common width for comparing the pending count against the 10-bit threshold
   localparam int CMP_W  = (PEND_W > 10) ? PEND_W : 10;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_CYCLES - 1);

   // ------------------------------------------------------------------
   // Tick prescaler
   // ------------------------------------------------------------------
   logic [PS_W-1:0] presc;
   logic            tick;

   always_ff @(posedge aclk) begin
      if (rst || !tx_en) begin
         presc <= '0;
      end else if (presc == PS_LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + PS_W'(1);
      end
   end

   assign tick = tx_en && (presc == PS_LAST);

   // ------------------------------------------------------------------
   // Write-back qualification and TXDW decision
   // ------------------------------------------------------------------
   logic [15:0] tidv_cnt;
   logic [15:0] tadv_cnt;
   logic        tidv_run;
   logic        tadv_run;
   logic        wb_q;
   logic        wb_imm;
   logic        wb_dly;
   logic        flush_hit;
   logic        tidv_exp;
   logic        tadv_exp;
   logic        fire;

   assign delay_pending = tidv_run || tadv_run;

   always_comb begin
      wb_q      = wb_valid && wb_rs && tx_en;
      wb_imm    = wb_q && (!wb_ide || (tidv == 16'd0));
      wb_dly    = wb_q && wb_ide && (tidv != 16'd0);
      flush_hit = flush && delay_pending && tx_en;
      // A running counter holding 1 reaches 0 on this tick. A reload in the
      // same cycle takes precedence over a TIDV expiry, but not over TADV.
      tidv_exp  = tidv_run && tick && (tidv_cnt == 16'd1) && !wb_dly;
      tadv_exp  = tadv_run && tick && (tadv_cnt == 16'd1);
      // Every term already requires tx_en, so nothing fires while disabled
      fire      = wb_imm || flush_hit || tidv_exp || tadv_exp;
   end

   // ------------------------------------------------------------------
   // TIDV / TADV timers
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (rst || !tx_en || fire) begin
         // Firing delivers (and disabling discards) whatever was held
         tidv_run <= 1'b0;
         tidv_cnt <= 16'd0;
         tadv_run <= 1'b0;
         tadv_cnt <= 16'd0;
      end else begin
         if (wb_dly) begin
            tidv_run <= 1'b1;
            tidv_cnt <= tidv;
         end else if (tidv_run && tick) begin
            tidv_cnt <= tidv_cnt - 16'd1;
         end

         // TADV bounds the total hold time, so it is only armed by the first
         // delayed write-back and never restarted while running.
         if (wb_dly && !tadv_run && (tadv != 16'd0)) begin
            tadv_run <= 1'b1;
            tadv_cnt <= tadv;
         end else if (tadv_run && tick) begin
            tadv_cnt <= tadv_cnt - 16'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Ring occupancy
   // ------------------------------------------------------------------
   logic [PEND_W-1:0] pending;
   logic [PEND_W-1:0] prev_pending;
   logic              prev_empty;
   logic              ring_ok;
   logic              ring_empty;
   logic [9:0]        thr;
   logic [CMP_W-1:0]  pend_ext;
   logic [CMP_W-1:0]  prev_ext;
   logic [CMP_W-1:0]  thr_ext;

   always_comb begin
      pending = '0;
      if (ring_len != '0) begin
         if (tdt >= tdh) begin
            pending = {1'b0, tdt} - {1'b0, tdh};
         end else begin
            pending = {1'b0, tdt} + {1'b0, ring_len} - {1'b0, tdh};
         end
      end
   end

   assign ring_ok    = (ring_len != '0);
   assign ring_empty = (tdh == tdt);
   assign thr        = {lwthresh, 3'b000};
   assign pend_ext   = CMP_W'(pending);
   assign prev_ext   = CMP_W'(prev_pending);
   assign thr_ext    = CMP_W'(thr);

   // ------------------------------------------------------------------
   // Cause pulses
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (rst) begin
         txdw_set     <= 1'b0;
         txqe_set     <= 1'b0;
         txd_low_set  <= 1'b0;
         prev_empty   <= 1'b1;
         prev_pending <= '0;
      end else begin
         txdw_set     <= fire;
         txqe_set     <= tx_en && ring_ok && ring_empty && !prev_empty;
         txd_low_set  <= tx_en && ring_ok && (lwthresh != 7'd0) &&
                         (prev_ext >= thr_ext) && (pend_ext < thr_ext);
         // Forcing prev_empty while disabled keeps an already-empty ring
         // from raising TXQE when the transmitter is re-enabled.
         prev_empty   <= tx_en ? ring_empty : 1'b1;
         prev_pending <= pending;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_e1000_tx_intr_moderator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_e1000_tx_intr_moderator
//  Purpose  : Self-checking bench for e1000_tx_intr_moderator: a directed
//             vector table, multi-cycle timer sequences, and randomized
//             traffic compared against a deadline-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_e1000_tx_intr_moderator;

   localparam int TICK = 4;
   localparam int IW   = 16;

   logic          aclk = 1'b0;
   logic          rst;
   logic          tx_en;
   logic          wb_valid;
   logic          wb_ide;
   logic          wb_rs;
   logic [IW-1:0] tdh;
   logic [IW-1:0] tdt;
   logic [IW-1:0] ring_len;
   logic [15:0]   tidv;
   logic [15:0]   tadv;
   logic [6:0]    lwthresh;
   logic          flush;
   logic          txdw_set;
   logic          txqe_set;
   logic          txd_low_set;
   logic          delay_pending;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 aclk = ~aclk;

   e1000_tx_intr_moderator #(
      .TICK_CYCLES (TICK),
      .IDX_WIDTH   (IW)
   ) dut (
      .aclk          (aclk),
      .rst           (rst),
      .tx_en         (tx_en),
      .wb_valid      (wb_valid),
      .wb_ide        (wb_ide),
      .wb_rs         (wb_rs),
      .tdh           (tdh),
      .tdt           (tdt),
      .ring_len      (ring_len),
      .tidv          (tidv),
      .tadv          (tadv),
      .lwthresh      (lwthresh),
      .flush         (flush),
      .txdw_set      (txdw_set),
      .txqe_set      (txqe_set),
      .txd_low_set   (txd_low_set),
      .delay_pending (delay_pending)
   );

   // ------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------
   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      tx_en    = 1'b1;
      wb_valid = 1'b0;
      flush    = 1'b0;
      @(posedge aclk);
      #1;
      rst = 1'b0;
   endtask

   // ------------------------------------------------------------------
   // Directed vector table (tidv=16, tadv=0 throughout)
   // ------------------------------------------------------------------
   typedef struct {
      logic          rst;
      logic          en;
      logic          wbv;
      logic          ide;
      logic          rs;
      logic          fl;
      logic [IW-1:0] tdh;
      logic [IW-1:0] tdt;
      logic [IW-1:0] rl;
      logic [6:0]    lw;
      logic          e_dw;
      logic          e_qe;
      logic          e_low;
      logic          e_dp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic en, input logic wbv, input logic ide,
                      input logic rs, input logic fl, input int h, input int t,
                      input int rl, input int lw, input logic dw, input logic qe,
                      input logic low, input logic dp);
      vec_t v;
      v.rst = r;  v.en = en; v.wbv = wbv; v.ide = ide; v.rs = rs; v.fl = fl;
      v.tdh = IW'(h); v.tdt = IW'(t); v.rl = IW'(rl); v.lw = 7'(lw);
      v.e_dw = dw; v.e_qe = qe; v.e_low = low; v.e_dp = dp;
      vecs.push_back(v);
   endtask

   // ------------------------------------------------------------------
   // Reference model: timers as absolute tick deadlines
   // ------------------------------------------------------------------
   int m_en_cnt;
   int m_ticks;
   bit m_tidv_on;
   int m_tidv_dl;
   bit m_tadv_on;
   int m_tadv_dl;
   bit m_prev_empty;
   int m_prev_p;
   bit e_dw, e_qe, e_low, e_dp;

   task automatic model_reset();
      m_en_cnt = 0; m_ticks = 0;
      m_tidv_on = 0; m_tidv_dl = 0; m_tadv_on = 0; m_tadv_dl = 0;
      m_prev_empty = 1; m_prev_p = 0;
      e_dw = 0; e_qe = 0; e_low = 0; e_dp = 0;
   endtask

   // Predicts the outputs seen after the coming clock edge
   task automatic model_step();
      bit tk, q, imm, dly, held, fl, texp, aexp, fire, empty;
      int p, thr;
      if (rst) begin
         model_reset();
         return;
      end
      tk       = tx_en && ((m_en_cnt % TICK) == TICK - 1);
      m_en_cnt = tx_en ? m_en_cnt + 1 : 0;
      if (tk) m_ticks++;

      q    = wb_valid && wb_rs && tx_en;
      imm  = q && (!wb_ide || tidv == 0);
      dly  = q && wb_ide && tidv != 0;
      held = m_tidv_on || m_tadv_on;
      fl   = flush && held && tx_en;
      texp = m_tidv_on && tk && (m_ticks == m_tidv_dl) && !dly;
      aexp = m_tadv_on && tk && (m_ticks == m_tadv_dl);
      fire = tx_en && (imm || fl || texp || aexp);

      if (!tx_en || fire) begin
         m_tidv_on = 0;
         m_tadv_on = 0;
      end else if (dly) begin
         m_tidv_on = 1;
         m_tidv_dl = m_ticks + int'(tidv);
         if (!m_tadv_on && tadv != 0) begin
            m_tadv_on = 1;
            m_tadv_dl = m_ticks + int'(tadv);
         end
      end
      e_dw = fire;
      e_dp = m_tidv_on || m_tadv_on;

      p = 0;
      if (ring_len != 0)
         p = (tdt >= tdh) ? int'(tdt) - int'(tdh) : int'(tdt) + int'(ring_len) - int'(tdh);
      thr   = int'(lwthresh) * 8;
      empty = (tdh == tdt);
      e_qe  = tx_en && ring_len != 0 && empty && !m_prev_empty;
      e_low = tx_en && ring_len != 0 && lwthresh != 0 && m_prev_p >= thr && p < thr;
      m_prev_empty = tx_en ? empty : 1'b1;
      m_prev_p     = p;
   endtask

   // ------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   int pulses;
   int first_hit;
   bit dp_at_hit;

   initial begin
      rst = 1'b1; tx_en = 1'b0; wb_valid = 1'b0; wb_ide = 1'b0; wb_rs = 1'b0;
      tdh = '0; tdt = '0; ring_len = IW'(8); tidv = 16'd16; tadv = 16'd0;
      lwthresh = 7'd1; flush = 1'b0;

      //  rst en wbv ide rs fl  tdh tdt rl lw   dw qe low dp
      add(1, 0, 0, 0, 0, 0,   0,  0, 8, 1,   0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0,   0,  0, 8, 1,   0, 0, 0, 0); // enable on empty ring
      add(0, 1, 0, 0, 0, 0,   0,  3, 8, 1,   0, 0, 0, 0);
      add(0, 1, 1, 0, 1, 0,   0,  3, 8, 1,   1, 0, 0, 0); // immediate TXDW
      add(0, 1, 0, 0, 0, 0,   0,  3, 8, 1,   0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0,   0,  3, 8, 1,   0, 0, 0, 0); // RS=0 ignored
      add(0, 1, 0, 0, 0, 0,   3,  3, 8, 1,   0, 1, 0, 0); // ring drains
      add(0, 1, 0, 0, 0, 0,   3,  3, 8, 1,   0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0,   0, 12,16, 1,   0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0,   4, 12,16, 1,   0, 0, 0, 0); // pending 8
      add(0, 1, 0, 0, 0, 0,   5, 12,16, 1,   0, 0, 1, 0); // 8 -> 7
      add(0, 1, 0, 0, 0, 0,   6, 12,16, 1,   0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0,  12, 12,16, 1,   0, 1, 0, 0);
      add(0, 1, 0, 0, 0, 0,  15,  2,16, 1,   0, 0, 0, 0); // wrapped, pending 3
      add(0, 1, 0, 0, 0, 0,   0,  2,16, 1,   0, 0, 0, 0); // head wraps 15->0
      add(0, 1, 0, 0, 0, 0,   2, 10,16, 1,   0, 0, 0, 0); // re-arm at 8
      add(0, 1, 1, 0, 1, 0,   3, 10,16, 1,   1, 0, 1, 0); // TXDW and TXD_LOW together
      add(0, 1, 0, 0, 0, 0,  10, 10,16, 1,   0, 1, 0, 0);
      add(0, 1, 0, 0, 0, 0,   0,  5, 0, 1,   0, 0, 0, 0); // ring invalid
      add(0, 1, 0, 0, 0, 0,   5,  5, 0, 1,   0, 0, 0, 0); // no TXQE on invalid ring
      add(0, 1, 0, 0, 0, 0,   0, 12,16, 0,   0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0,   6, 12,16, 0,   0, 0, 0, 0); // lwthresh=0 disables
      add(0, 1, 1, 1, 1, 0,   6, 12,16, 0,   0, 0, 0, 1); // delayed TXDW held
      add(0, 1, 0, 0, 0, 1,   6, 12,16, 0,   1, 0, 0, 0); // flush fires it
      add(0, 1, 0, 0, 0, 1,   6, 12,16, 0,   0, 0, 0, 0); // flush with nothing held
      add(0, 0, 0, 0, 0, 0,   6,  6,16, 0,   0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0,   6,  6,16, 0,   0, 0, 0, 0); // re-enable on empty ring

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; tx_en = vecs[i].en; wb_valid = vecs[i].wbv;
         wb_ide = vecs[i].ide; wb_rs = vecs[i].rs; flush = vecs[i].fl;
         tdh = vecs[i].tdh; tdt = vecs[i].tdt; ring_len = vecs[i].rl;
         lwthresh = vecs[i].lw;
         @(posedge aclk);
         #1;
         check($sformatf("vec%0d.txdw", i), txdw_set, vecs[i].e_dw);
         check($sformatf("vec%0d.txqe", i), txqe_set, vecs[i].e_qe);
         check($sformatf("vec%0d.txd_low", i), txd_low_set, vecs[i].e_low);
         check($sformatf("vec%0d.delay_pending", i), delay_pending, vecs[i].e_dp);
      end
      wb_valid = 1'b0; flush = 1'b0;

      // IDE set but TIDV=0 takes the immediate path
      tidv = 16'd0; wb_valid = 1'b1; wb_ide = 1'b1; wb_rs = 1'b1;
      @(posedge aclk);
      #1;
      wb_valid = 1'b0;
      check("tidv0.txdw", txdw_set, 1'b1);
      check("tidv0.delay_pending", delay_pending, 1'b0);

      // TIDV restart: write-backs at 0 and 40, one TXDW ~64 cycles after 40
      do_reset();
      tidv = 16'd16; tadv = 16'd0; ring_len = IW'(8); tdh = '0; tdt = '0; lwthresh = 7'd0;
      pulses = 0; first_hit = -1;
      for (int c = 0; c < 120; c++) begin
         wb_valid = (c == 0 || c == 40); wb_ide = 1'b1; wb_rs = 1'b1;
         @(posedge aclk);
         #1;
         if (txdw_set) begin
            pulses++;
            if (first_hit < 0) first_hit = c;
         end
      end
      wb_valid = 1'b0;
      check_int("tidv_restart.pulses", pulses, 1, 1);
      check_int("tidv_restart.time", first_hit, 100, 108);

      // TADV bound: write-backs every 30 cycles keep TIDV alive; TADV fires
      do_reset();
      tidv = 16'd16; tadv = 16'd32;
      pulses = 0; first_hit = -1; dp_at_hit = 1'b1;
      for (int c = 0; c < 140; c++) begin
         wb_valid = ((c % 30) == 0); wb_ide = 1'b1; wb_rs = 1'b1;
         @(posedge aclk);
         #1;
         if (c == 60) check("tadv.held_dp", delay_pending, 1'b1);
         if (txdw_set) begin
            pulses++;
            if (first_hit < 0) begin
               first_hit = c;
               dp_at_hit = delay_pending;
            end
         end
      end
      wb_valid = 1'b0;
      check_int("tadv.pulses", pulses, 1, 1);
      check_int("tadv.time", first_hit, 124, 132);
      check("tadv.dp_dropped", dp_at_hit, 1'b0);

      // tx_en dropped mid-countdown discards the held TXDW
      do_reset();
      tidv = 16'd16; tadv = 16'd0; pulses = 0;
      for (int c = 0; c < 130; c++) begin
         wb_valid = (c == 0); wb_ide = 1'b1; wb_rs = 1'b1;
         tx_en = (c != 20);
         @(posedge aclk);
         #1;
         if (c == 10) check("en_drop.dp_before", delay_pending, 1'b1);
         if (c == 20) begin
            check("en_drop.dp_after", delay_pending, 1'b0);
            check("en_drop.txdw_after", txdw_set, 1'b0);
         end
         if (txdw_set) pulses++;
      end
      wb_valid = 1'b0; tx_en = 1'b1;
      check_int("en_drop.pulses", pulses, 0, 0);

      // rst mid-countdown discards the held TXDW
      do_reset();
      pulses = 0;
      for (int c = 0; c < 130; c++) begin
         wb_valid = (c == 0); wb_ide = 1'b1; wb_rs = 1'b1;
         rst = (c == 20);
         @(posedge aclk);
         #1;
         if (c == 10) check("rst_mid.dp_before", delay_pending, 1'b1);
         if (c == 20) check("rst_mid.dp_after", delay_pending, 1'b0);
         if (txdw_set) pulses++;
      end
      wb_valid = 1'b0; rst = 1'b0;
      check_int("rst_mid.pulses", pulses, 0, 0);

      // Randomized traffic against the reference model
      do_reset();
      model_reset();
      tidv = 16'd3; tadv = 16'd6; ring_len = IW'(16); lwthresh = 7'd1;
      tdh = '0; tdt = '0;
      for (int c = 0; c < 3000; c++) begin
         if ((c % 200) == 0) begin
            int sel;
            tidv     = 16'($urandom_range(0, 8));
            tadv     = 16'($urandom_range(0, 12));
            lwthresh = 7'($urandom_range(0, 3));
            sel      = int'($urandom_range(0, 3));
            ring_len = (sel == 0) ? IW'(0) : IW'(8 << (sel - 1));
            if (ring_len != 0) begin
               tdh = IW'(int'(tdh) % int'(ring_len));
               tdt = IW'(int'(tdt) % int'(ring_len));
            end
         end
         rst      = ($urandom_range(0, 699) == 0);
         tx_en    = ($urandom_range(0, 79) != 0);
         wb_valid = ($urandom_range(0, 5) == 0);
         wb_rs    = ($urandom_range(0, 3) != 0);
         wb_ide   = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 39) == 0);
         if (ring_len != 0) begin
            if ($urandom_range(0, 2) == 0)
               tdt = IW'((int'(tdt) + int'($urandom_range(0, 3))) % int'(ring_len));
            else if ($urandom_range(0, 1) == 0 && tdh != tdt)
               tdh = IW'((int'(tdh) + 1) % int'(ring_len));
         end
         model_step();
         @(posedge aclk);
         #1;
         check($sformatf("rand%0d.txdw", c), txdw_set, e_dw);
         check($sformatf("rand%0d.txqe", c), txqe_set, e_qe);
         check($sformatf("rand%0d.txd_low", c), txd_low_set, e_low);
         check($sformatf("rand%0d.delay_pending", c), delay_pending, e_dp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
